// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   - state_t : controller state encoding (IDLE / RUN / DONE)
//   - FA_*    : bit positions of the full_adder input/output vectors
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // full_adder input vector bit map
  localparam int FA_A   = 0;
  localparam int FA_B   = 1;
  localparam int FA_CIN = 2;

  // full_adder output vector bit map
  localparam int FA_S   = 0;
  localparam int FA_CO  = 1;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder shared by the serial controller.
// Ports:
//   in  [2:0] : {carry-in, b, a} at positions FA_CIN / FA_B / FA_A
//   out [1:0] : {carry-out, sum} at positions FA_CO / FA_S
module full_adder
  import adder_pkg::*;
(
  input  logic [2:0] in,
  output logic [1:0] out
);

  // Sum is the parity of all three inputs; carry is generated by a&b or
  // propagated from carry-in when exactly one of a/b is set.
  always_comb begin
    out         = '0;
    out[FA_S]   = in[FA_A] ^ in[FA_B] ^ in[FA_CIN];
    out[FA_CO]  = (in[FA_A] & in[FA_B]) | (in[FA_CIN] & (in[FA_A] ^ in[FA_B]));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full_adder with one operand bit
// per clock, LSB first, keeping the ripple carry in a register.
// Parameters:
//   WIDTH : operand/sum width in bits (1..32)
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : add request, only honoured while idle
//   a, b  : operands, captured in the cycle start is accepted
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when sum/cout become final
//   sum   : a+b mod 2^WIDTH, held until the next accepted start
//   cout  : carry out of the top bit, held with sum
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_bitCount;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_faIn;
  logic [1:0]       w_faOut;

  // The adder always sees the current LSBs of the operand shift registers
  // plus the carry produced by the previous bit.
  assign w_faIn[FA_A]   = r_aShift[0];
  assign w_faIn[FA_B]   = r_bShift[0];
  assign w_faIn[FA_CIN] = r_carry;

  full_adder u_fullAdder (
    .in  (w_faIn),
    .out (w_faOut)
  );

  // Single controller process: state, datapath registers and the
  // registered handshake outputs all advance together. The sum bit enters
  // from the MSB side, so after WIDTH shifts bit 0 has reached position 0;
  // the concatenate-then-shift form keeps this legal for WIDTH=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_sum      <= '0;
      r_bitCount <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_aShift   <= a;
            r_bShift   <= b;
            r_carry    <= 1'b0;
            r_bitCount <= '0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_sum      <= WIDTH'({w_faOut[FA_S], r_sum} >> 1);
          r_aShift   <= r_aShift >> 1;
          r_bShift   <= r_bShift >> 1;
          r_carry    <= w_faOut[FA_CO];
          r_bitCount <= r_bitCount + 1'b1;
          if (r_bitCount == LAST_BIT) begin
            r_cout  <= w_faOut[FA_CO];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=8 instance driven by
// a vector table, random operands against an arithmetic reference, and
// hand-written multi-cycle sequences; plus an exhaustive WIDTH=1 instance.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Watchdog so a stuck design still ends the run with a failure line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One complete WIDTH=8 operation from an idle DUT. Operands are scrambled
  // right after acceptance to show they are not re-sampled.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [7:0] es, input logic ec,
                               input string tag);
    int lat;
    int busyCnt;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1; busyCnt = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (done8) seen = 1;
      else begin
        if (busy8) busyCnt++;
        @(negedge clk);
        lat++;
      end
    end
    checkOutput({tag, "_latency"}, seen ? lat : -1, 9);
    checkOutput({tag, "_busyCycles"}, busyCnt, 8);
    checkOutput({tag, "_busyAtDone"}, {31'd0, busy8}, 0);
    checkOutput({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    checkOutput({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, {31'd0, done8}, 0);
  endtask

  initial begin
    int doneCycles[$];
    int expCycles[$];
    logic [8:0] refSum;
    logic [7:0] ra, rb;
    logic [1:0] exp1;

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state, with start requested during reset to show it is dropped.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy8}, 0);
    checkOutput("rst_done", {31'd0, done8}, 0);
    checkOutput("rst_sum", {24'd0, sum8}, 0);
    checkOutput("rst_cout", {31'd0, cout8}, 0);
    checkOutput("rst_w1", {29'd0, busy1, done1, sum1, cout1}, 0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy8}, 0);

    // Table-driven vectors
    vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 8'h30, 1'b0};
    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expSum, vecs[i].expCout,
                    $sformatf("vec%0d", i));

    // Random operands against plain 9-bit addition
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      refSum = {1'b0, ra} + {1'b0, rb};
      applyStimulus(ra, rb, refSum[7:0], refSum[8], $sformatf("rand%0d", i));
    end

    // start re-pulsed mid-run must be ignored
    doneCycles.delete();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (done8) begin
        doneCycles.push_back(c);
        checkOutput("repulse_sum", {24'd0, sum8}, 32'h8D);
        checkOutput("repulse_cout", {31'd0, cout8}, 0);
      end
      if (c == 0) begin start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; end
      else if (c == 4) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      else start8 = 1'b0;
    end
    checkOutput("repulse_doneCount", doneCycles.size(), 1);
    if (doneCycles.size() > 0) checkOutput("repulse_doneCycle", doneCycles[0], 9);

    // start held high: one result every WIDTH+2 cycles
    expCycles.delete();
    for (int k = 9; k < 30; k += 10) expCycles.push_back(k);
    doneCycles.delete();
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (done8) begin
        doneCycles.push_back(c);
        checkOutput("held_sum", {24'd0, sum8}, 32'h30);
      end
      if (c < 30) begin start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; end
      else start8 = 1'b0;
    end
    checkOutput("held_doneCount", doneCycles.size(), expCycles.size());
    for (int i = 0; i < doneCycles.size() && i < expCycles.size(); i++)
      checkOutput($sformatf("held_doneCycle%0d", i), doneCycles[i], expCycles[i]);
    @(negedge clk);

    // Reset in the middle of a run discards the result without a done pulse
    doneCycles.delete();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (done8) doneCycles.push_back(c);
      if (c == 6) begin
        checkOutput("midrst_busy", {31'd0, busy8}, 0);
        checkOutput("midrst_sum", {24'd0, sum8}, 0);
        checkOutput("midrst_cout", {31'd0, cout8}, 0);
      end
      start8 = (c == 0);
      if (c == 0) begin a8 = 8'h5A; b8 = 8'h33; end
      rst = (c == 5);
    end
    checkOutput("midrst_noDone", doneCycles.size(), 0);
    applyStimulus(8'h5A, 8'h33, 8'h8D, 1'b0, "afterRst");

    // WIDTH=1: exhaustive, done two cycles after start
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = 1'(i >> 1); b1 = 1'(i);
      exp1 = {1'b0, a1} + {1'b0, b1};
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1;
      checkOutput($sformatf("w1_busy%0d", i), {30'd0, busy1, done1}, 32'h2);
      @(negedge clk);
      checkOutput($sformatf("w1_done%0d", i), {31'd0, done1}, 1);
      checkOutput($sformatf("w1_result%0d", i), {30'd0, cout1, sum1}, {30'd0, exp1});
      @(negedge clk);
      checkOutput($sformatf("w1_pulse%0d", i), {31'd0, done1}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
